// File: rtl/fpga_rst_pkg.sv
// Shared types for the reset sequencer: FSM state, reset cause, counter sizing.
package fpga_rst_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_BTN  = 2'd1,
    CAUSE_JTAG = 2'd2,
    CAUSE_SW   = 2'd3
  } cause_e;

  // Width needed to hold 0..max_val, never zero.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fpga_debounce.sv
// Synchronizer chain followed by a symmetric debouncer: the filtered value
// follows the synchronized input only after DebounceCycles consecutive differing samples.
module fpga_debounce
  import fpga_rst_pkg::*;
#(
  parameter int   SyncStages     = 2,
  parameter int   DebounceCycles = 1000,
  parameter logic RstVal         = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  localparam int CntW = cnt_w(DebounceCycles - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic [CntW-1:0]       cnt_q;
  logic                  s;

  assign s = sync_q[SyncStages-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SyncStages{RstVal}};
      cnt_q  <= '0;
      q_o    <= RstVal;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], d_i};
      if (s == q_o) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        q_o   <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/fpga_rst_seq.sv
// Board reset sequencer: filters external causes, holds all domains in reset,
// waits for PLL lock, then releases domains one by one HoldCycles apart.
module fpga_rst_seq
  import fpga_rst_pkg::*;
#(
  parameter int NumStages      = 3,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 1000,
  parameter int HoldCycles     = 16,
  parameter int RefClkHz       = 50_000_000,
  parameter int RtcHz          = 1_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 btn_rst_i,
  input  logic                 trst_ni,
  input  logic                 pll_locked_i,
  input  logic                 sw_rst_req_i,
  output logic [NumStages-1:0] rst_no,
  output logic                 all_released_o,
  output logic                 busy_o,
  output logic [1:0]           cause_o,
  output logic                 rtc_o
);

  if (RefClkHz % (2 * RtcHz) != 0) begin : g_bad_rtc
    $error("RefClkHz must be divisible by 2*RtcHz");
  end

  localparam int RtcDiv = RefClkHz / (2 * RtcHz);
  localparam int HoldW  = cnt_w(HoldCycles - 1);
  localparam int RelW   = cnt_w(NumStages);
  localparam int RtcW   = cnt_w(RtcDiv - 1);

  logic btn_db, trst_db, lock_s;
  logic [SyncStages-1:0] lock_sync;

  fpga_debounce #(.SyncStages(SyncStages), .DebounceCycles(DebounceCycles), .RstVal(1'b0))
    u_btn_db (.clk_i(clk_i), .rst_i(rst_i), .d_i(btn_rst_i), .q_o(btn_db));

  fpga_debounce #(.SyncStages(SyncStages), .DebounceCycles(DebounceCycles), .RstVal(1'b1))
    u_trst_db (.clk_i(clk_i), .rst_i(rst_i), .d_i(trst_ni), .q_o(trst_db));

  always_ff @(posedge clk_i) begin
    if (rst_i) lock_sync <= '0;
    else       lock_sync <= {lock_sync[SyncStages-2:0], pll_locked_i};
  end
  assign lock_s = lock_sync[SyncStages-1];

  state_e            state_q, state_d;
  logic [HoldW-1:0]  hold_q;
  logic [RelW-1:0]   rel_q;
  cause_e            cause_q, cause_sel;
  logic              ext_cause, lock_loss, sw_req, force_rst, hold_done;

  // Lock loss only counts once a release has started; before that, WAIT_LOCK absorbs it.
  assign ext_cause = btn_db | ~trst_db;
  assign lock_loss = ~lock_s & ((state_q == ST_RELEASE) || (state_q == ST_RUN));
  assign sw_req    = sw_rst_req_i & (state_q == ST_RUN);
  assign force_rst = ext_cause | lock_loss | sw_req;
  assign hold_done = (hold_q == HoldW'(HoldCycles - 1));

  always_comb begin
    cause_sel = CAUSE_SW;
    if (lock_loss)     cause_sel = CAUSE_POR;
    else if (btn_db)   cause_sel = CAUSE_BTN;
    else if (!trst_db) cause_sel = CAUSE_JTAG;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_ASSERT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ASSERT:    if (!ext_cause && hold_done) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (force_rst) state_d = ST_ASSERT;
                    else if (lock_s) state_d = (NumStages == 1) ? ST_RUN : ST_RELEASE;
      ST_RELEASE:   if (force_rst) state_d = ST_ASSERT;
                    else if (hold_done && rel_q == RelW'(NumStages - 1)) state_d = ST_RUN;
      ST_RUN:       if (force_rst) state_d = ST_ASSERT;
      default:      state_d = ST_ASSERT;
    endcase
  end

  // hold_q times both the quiet period in ASSERT and the spacing between releases.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q  <= '0;
      rel_q   <= '0;
      cause_q <= CAUSE_POR;
    end else begin
      if (state_q == ST_ASSERT && state_d == ST_ASSERT && !ext_cause)
        hold_q <= hold_q + HoldW'(1);
      else if (state_q == ST_RELEASE && state_d == ST_RELEASE)
        hold_q <= hold_done ? '0 : hold_q + HoldW'(1);
      else
        hold_q <= '0;

      if (state_d == ST_RELEASE)
        rel_q <= (state_q != ST_RELEASE) ? RelW'(1) : rel_q + (hold_done ? RelW'(1) : RelW'(0));
      else
        rel_q <= '0;

      if (state_q != ST_ASSERT && state_d == ST_ASSERT) cause_q <= cause_sel;
    end
  end

  always_comb begin
    all_released_o = (state_q == ST_RUN);
    busy_o         = (state_q != ST_RUN);
    cause_o        = cause_q;
  end

  for (genvar k = 0; k < NumStages; k++) begin : g_dom
    assign rst_no[k] = (state_q == ST_RUN) || ((state_q == ST_RELEASE) && (rel_q > RelW'(k)));
  end

  logic [RtcW-1:0] rtc_cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rtc_cnt_q <= '0;
      rtc_o     <= 1'b0;
    end else if (rtc_cnt_q == RtcW'(RtcDiv - 1)) begin
      rtc_cnt_q <= '0;
      rtc_o     <= ~rtc_o;
    end else begin
      rtc_cnt_q <= rtc_cnt_q + RtcW'(1);
    end
  end

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Bench for fpga_rst_seq: cycle model built from edge histories and release
// timestamps, checked every cycle, plus hand-computed directed expectations.
module tb_fpga_rst_seq;
  localparam int NS = 3, SS = 2, DB = 4, H = 8, REF = 8, RTC = 1;
  localparam int DIV = REF / (2 * RTC);
  localparam int M = 2047;

  logic clk = 1'b0;
  logic rst_i = 1'b1, btn_rst_i = 1'b0, trst_ni = 1'b1, pll_locked_i = 1'b1, sw_rst_req_i = 1'b0;
  logic [NS-1:0] rst_no;
  logic all_released_o, busy_o, rtc_o;
  logic [1:0] cause_o;

  fpga_rst_seq #(.NumStages(NS), .SyncStages(SS), .DebounceCycles(DB), .HoldCycles(H),
                 .RefClkHz(REF), .RtcHz(RTC)) dut (
    .clk_i(clk), .rst_i(rst_i), .btn_rst_i(btn_rst_i), .trst_ni(trst_ni),
    .pll_locked_i(pll_locked_i), .sw_rst_req_i(sw_rst_req_i), .rst_no(rst_no),
    .all_released_o(all_released_o), .busy_o(busy_o), .cause_o(cause_o), .rtc_o(rtc_o));

  always #5 clk = ~clk;

  int cyc = 0, total = 0, bad = 0;

  // Model state: effective input per edge, filtered causes, quiet-cycle count,
  // edge at which domain 0 was released (-1 while held), last cause, rtc edge count.
  bit h_btn[0:M], h_jt[0:M], h_lock[0:M];
  bit m_btn_db = 0, m_jt_db = 0;
  int m_quiet = 0, m_rel_t = -1, m_rtc_k = 0;
  logic [1:0] m_cause = 2'd0;

  always @(posedge clk) begin : model
    bit lock_seen, prev_run, ll, swq, eq_b, eq_j;
    int n;
    cyc++;
    n = cyc;
    h_btn[n & M]  = rst_i ? 1'b0 : btn_rst_i;
    h_jt[n & M]   = rst_i ? 1'b0 : !trst_ni;
    h_lock[n & M] = rst_i ? 1'b0 : pll_locked_i;
    lock_seen = (n >= 2) ? h_lock[(n - 2) & M] : 1'b0;
    if (rst_i) begin
      m_quiet = 0; m_rel_t = -1; m_cause = 2'd0; m_rtc_k = 0;
      m_btn_db = 0; m_jt_db = 0;
    end else begin
      m_rtc_k++;
      if (m_rel_t >= 0) begin
        prev_run = (n - 1 - m_rel_t) >= (NS - 1) * H;
        ll  = !lock_seen;
        swq = sw_rst_req_i && prev_run;
        if (ll || m_btn_db || m_jt_db || swq) begin
          m_cause = ll ? 2'd0 : m_btn_db ? 2'd1 : m_jt_db ? 2'd2 : 2'd3;
          m_rel_t = -1; m_quiet = 0;
        end
      end else if (m_quiet < H) begin
        if (m_btn_db || m_jt_db) m_quiet = 0;
        else m_quiet++;
      end else begin
        if (m_btn_db || m_jt_db) begin
          m_cause = m_btn_db ? 2'd1 : 2'd2;
          m_quiet = 0;
        end else if (lock_seen) m_rel_t = n;
      end
      // filtered value takes the synchronized sample once DB equal samples are seen in a row
      eq_b = 1; eq_j = 1;
      for (int i = 3; i < DB + 2; i++) begin
        if (h_btn[(n - i) & M] != h_btn[(n - 2) & M]) eq_b = 0;
        if (h_jt[(n - i) & M] != h_jt[(n - 2) & M]) eq_j = 0;
      end
      if (n >= DB + 2 && eq_b) m_btn_db = h_btn[(n - 2) & M];
      if (n >= DB + 2 && eq_j) m_jt_db = h_jt[(n - 2) & M];
    end
  end

  always @(negedge clk) begin : compare
    logic [NS-1:0] e_rst;
    bit e_all, e_rtc;
    if (cyc >= 1) begin
      for (int k = 0; k < NS; k++) e_rst[k] = (m_rel_t >= 0) && ((cyc - m_rel_t) >= k * H);
      e_all = (m_rel_t >= 0) && ((cyc - m_rel_t) >= (NS - 1) * H);
      e_rtc = ((m_rtc_k / DIV) % 2) == 1;
      total++;
      if ({rst_no, all_released_o, busy_o, cause_o, rtc_o} !== {e_rst, e_all, !e_all, m_cause, e_rtc}) begin
        bad++;
        $display("FAIL model cyc=%0d got rst_no=%b rel=%b busy=%b cause=%0d rtc=%b want rst_no=%b rel=%b busy=%b cause=%0d rtc=%b",
                 cyc, rst_no, all_released_o, busy_o, cause_o, rtc_o, e_rst, e_all, !e_all, m_cause, e_rtc);
      end
    end
  end

  task automatic at_edge(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  task automatic wait_released(input string name);
    for (int i = 0; i < 200 && !all_released_o; i++) @(negedge clk);
    total++;
    if (!all_released_o) begin
      bad++;
      $display("FAIL %s timeout cyc=%0d got rel=%b want rel=1", name, cyc, all_released_o);
    end
  endtask

  initial begin : stim
    int c;
    // power-on reset, five cycles
    at_edge(5);
    chk("rst_rst_no", 32'(rst_no), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h1);
    chk("rst_all", 32'(all_released_o), 32'h0);
    chk("rst_cause", 32'(cause_o), 32'h0);
    chk("rst_rtc", 32'(rtc_o), 32'h0);
    rst_i = 1'b0;
    at_edge(8);  chk("rtc_low_8", 32'(rtc_o), 32'h0);
    at_edge(9);  chk("rtc_high_9", 32'(rtc_o), 32'h1);
    at_edge(13); chk("por_held_13", 32'(rst_no), 32'h0);
                 chk("rtc_low_13", 32'(rtc_o), 32'h0);
    at_edge(14); chk("por_d0_14", 32'(rst_no), 32'h1);
    at_edge(21); chk("por_d0_21", 32'(rst_no), 32'h1);
    at_edge(22); chk("por_d1_22", 32'(rst_no), 32'h3);
    at_edge(29); chk("por_all_29", 32'(all_released_o), 32'h0);
    at_edge(30); chk("por_d2_30", 32'(rst_no), 32'h7);
                 chk("por_all_30", 32'(all_released_o), 32'h1);
                 chk("por_cause", 32'(cause_o), 32'h0);

    // button held 10 cycles in RUN
    c = cyc; btn_rst_i = 1'b1;
    at_edge(c + 6);  chk("btn_pre", 32'(rst_no), 32'h7);
    at_edge(c + 7);  chk("btn_assert", 32'(rst_no), 32'h0);
                     chk("btn_cause", 32'(cause_o), 32'h1);
    at_edge(c + 10); btn_rst_i = 1'b0;
    wait_released("btn_recover");

    // 3-cycle glitch is filtered out
    c = cyc; btn_rst_i = 1'b1;
    at_edge(c + 3);  btn_rst_i = 1'b0;
    at_edge(c + 20); chk("glitch_rst_no", 32'(rst_no), 32'h7);
                     chk("glitch_busy", 32'(busy_o), 32'h0);

    // software reset from RUN, then JTAG mid-release with an ignored sw pulse
    c = cyc; sw_rst_req_i = 1'b1;
    at_edge(c + 1);  sw_rst_req_i = 1'b0;
                     chk("sw_assert", 32'(rst_no), 32'h0);
                     chk("sw_cause", 32'(cause_o), 32'h3);
    at_edge(c + 10); chk("sw_d0", 32'(rst_no), 32'h1);
    at_edge(c + 12); sw_rst_req_i = 1'b1;
    at_edge(c + 13); sw_rst_req_i = 1'b0;
                     chk("sw_ignored", 32'(rst_no), 32'h1);
    at_edge(c + 18); chk("rel_d1", 32'(rst_no), 32'h3);
                     trst_ni = 1'b0;
    at_edge(c + 24); chk("jtag_pre", 32'(rst_no), 32'h3);
    at_edge(c + 25); chk("jtag_assert", 32'(rst_no), 32'h0);
                     chk("jtag_cause", 32'(cause_o), 32'h2);
    at_edge(c + 30); trst_ni = 1'b1;
    wait_released("jtag_recover");

    // button and sw request reach the sequencer on the same edge
    c = cyc; btn_rst_i = 1'b1;
    at_edge(c + 6); sw_rst_req_i = 1'b1;
    at_edge(c + 7); sw_rst_req_i = 1'b0;
                    chk("simul_assert", 32'(rst_no), 32'h0);
                    chk("simul_cause", 32'(cause_o), 32'h1);
    at_edge(c + 8); btn_rst_i = 1'b0;
    wait_released("simul_recover");

    // PLL lock loss held for 50 cycles
    c = cyc; pll_locked_i = 1'b0;
    at_edge(c + 2);  chk("lock_pre", 32'(rst_no), 32'h7);
    at_edge(c + 3);  chk("lock_assert", 32'(rst_no), 32'h0);
                     chk("lock_cause", 32'(cause_o), 32'h0);
    at_edge(c + 50); chk("lock_wait_rst_no", 32'(rst_no), 32'h0);
                     chk("lock_wait_busy", 32'(busy_o), 32'h1);
                     chk("lock_wait_all", 32'(all_released_o), 32'h0);
    pll_locked_i = 1'b1;
    wait_released("lock_recover");
    chk("lock_final_cause", 32'(cause_o), 32'h0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpga_rst_seq.md
FPGA_RST_SEQ -- requirements
Module: fpga_rst_seq

Interface
REQ-001 SHALL have parameter NumStages, default 3, number of sequenced reset domains (1..8).
REQ-002 SHALL have parameter SyncStages, default 2, synchronizer depth for asynchronous inputs (>=2).
REQ-003 SHALL have parameter DebounceCycles, default 1000, cycles an input must be stable before its filtered value changes (>=1).
REQ-004 SHALL have parameter HoldCycles, default 16, minimum assert time and inter-stage release spacing (>=1).
REQ-005 SHALL have parameters RefClkHz, default 50_000_000, and RtcHz, default 1_000_000; RefClkHz not divisible by 2*RtcHz SHALL be an elaboration error.
REQ-006 SHALL have ports: clk_i  in  1  sole clock; rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: btn_rst_i  in  1  board reset button, async, active-high; trst_ni  in  1  JTAG reset, async, active-low; pll_locked_i  in  1  PLL lock, async.
REQ-008 SHALL have port sw_rst_req_i  in  1  single-cycle synchronous software reset request.
REQ-009 SHALL have ports: rst_no  out  NumStages  per-domain reset, active-low; all_released_o  out  1  all domains out of reset; busy_o  out  1  sequencer not in RUN.
REQ-010 SHALL have ports: cause_o  out  2  last reset cause (0 POR/PLL loss, 1 button, 2 JTAG, 3 software); rtc_o  out  1  square wave at RtcHz.

Function
REQ-011 SHALL synchronize btn_rst_i, trst_ni, pll_locked_i through SyncStages flops, then debounce btn and trst symmetrically over DebounceCycles.
REQ-012 SHALL drive all rst_no low exactly SyncStages+DebounceCycles+1 cycles after a stable button/JTAG assertion; sw_rst_req_i acts on the next edge.
REQ-013 FSM states: ASSERT, WAIT_LOCK, RELEASE, RUN; encoding from the shared package.
REQ-014 ASSERT: all rst_no low; hold counter cleared while any cause is active; exits to WAIT_LOCK after exactly HoldCycles consecutive cause-free cycles.
REQ-015 WAIT_LOCK: exits to RELEASE when synchronized lock is high (minimum 1 cycle); stays indefinitely otherwise.
REQ-016 RELEASE: rst_no[0] rises on the edge entering RELEASE; rst_no[k] rises exactly k*HoldCycles cycles after rst_no[0]; enter RUN with the last release.
REQ-017 RUN: all rst_no high, all_released_o high, busy_o low.
REQ-018 Any cause (button, JTAG, software, or lock loss) in WAIT_LOCK, RELEASE, or RUN SHALL force ASSERT with all rst_no low on the next edge, including mid-release.
REQ-019 sw_rst_req_i SHALL be ignored outside RUN.
REQ-020 cause_o SHALL update on ASSERT entry; simultaneous-cause priority: lock loss > button > JTAG > software.
REQ-021 rtc_o SHALL toggle every RefClkHz/(2*RtcHz) cycles, free-running, unaffected by sequencer state.
REQ-022 Counter widths SHALL be $clog2(max+1) of their terminal value; no wrap-around is permitted while counting.

Reset
REQ-023 On rst_i: state ASSERT, rst_no all 0, all_released_o 0, busy_o 1, cause_o 0, rtc_o 0, all counters 0, synchronizers/debouncers to the inactive value.
REQ-024 rst_i SHALL be treated as an active cause: ASSERT holds while rst_i is high.

Structure
REQ-025 Package fpga_rst_pkg SHALL hold the state enum and cause enum (2-bit) typedefs.
REQ-026 The sync+debounce SHALL be a sub-module fpga_debounce (parameters SyncStages, DebounceCycles), instantiated for the button and trst; the lock input uses the sync only.

Verification (NumStages=3, SyncStages=2, DebounceCycles=4, HoldCycles=8, RefClkHz=8, RtcHz=1)
REQ-027 POR: rst_i high 5 cycles, lock high -> rst_no[0] rises 9 cycles after the last rst_i-high cycle, rst_no[1] at 17, rst_no[2] and all_released_o at 25, cause_o=0.
REQ-028 Button: in RUN, btn high for 10 cycles -> rst_no=000 7 cycles after the rise, cause_o=1; a 3-cycle glitch -> no effect.
REQ-029 Mid-release: sw_rst_req_i pulse during RELEASE -> ignored; JTAG trst_ni low at the same point -> rst_no=000 next edge after the debounced value, cause_o=2, full re-sequence.
REQ-030 Lock: pll_locked_i low in RUN -> ASSERT with cause_o=0; held low 50 cycles -> stays in WAIT_LOCK, busy_o=1, rst_no=000.
REQ-031 Simultaneous: button and sw_rst_req_i seen on the same edge -> cause_o=1.
REQ-032 RTC: rtc_o period 8 cycles (4 high/4 low) continuous across button resets.
